// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder: ping-pong buffer that turns bit-reversed NTT output frames into natural order
// Optional NTT_REORDER_CANON_EN: inputs in [MODULUS, 2*MODULUS) are reduced once on write
module ntt_bitrev_reorder #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int MODULUS = 7681
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] incoming_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] reordered_data,
  output logic         out_last
);
  localparam int LOG2N = $clog2(N);
  logic [W-1:0] mem [2][N];
  logic [1:0] bank_full, bank_full_nx;
  logic wr_bank, rd_bank, wr_en, rd_en, wr_done, rd_done;
  logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_addr;
  logic [W-1:0] wr_data;
  for (genvar b = 0; b < LOG2N; b++) begin : g_rev
    assign wr_addr[b] = wr_cnt[LOG2N-1-b];
  end
`ifdef NTT_REORDER_CANON_EN
  assign wr_data = incoming_data >= W'(MODULUS) ? incoming_data - W'(MODULUS) : incoming_data;
`else
  assign wr_data = incoming_data;
`endif
  assign in_ready = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign reordered_data = out_valid ? mem[rd_bank][rd_cnt] : '0;
  assign out_last = out_valid && rd_cnt == LOG2N'(N-1);
  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;
  assign wr_done = wr_en && wr_cnt == LOG2N'(N-1);
  assign rd_done = rd_en && rd_cnt == LOG2N'(N-1);
  // set and clear always target different banks, so applying both is safe
  always_comb begin
    bank_full_nx = bank_full;
    if (wr_done) bank_full_nx[wr_bank] = 1'b1;
    if (rd_done) bank_full_nx[rd_bank] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (wr_done) wr_bank <= !wr_bank;
      if (rd_done) rd_bank <= !rd_bank;
      bank_full <= bank_full_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// tb_ntt_bitrev_reorder: scenario tasks checked against a frame-level bit-reversal model
module tb_ntt_bitrev_reorder;
  localparam int W = 32, N = 16, MODULUS = 7681, LOG2N = $clog2(N);
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] incoming_data = '0;
  logic in_ready, out_valid, out_last;
  logic [W-1:0] reordered_data;
  int vectors = 0, errors = 0;
  logic [W-1:0] in_buf[$], exp_q[$];
  int out_idx = 0;

  ntt_bitrev_reorder #(.W(W), .N(N), .MODULUS(MODULUS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .incoming_data(incoming_data), .out_valid(out_valid), .out_ready(out_ready),
    .reordered_data(reordered_data), .out_last(out_last));

  always #5 clk = !clk;

  function automatic int rev(int i);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + i % 2;
      i = i / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] canon(logic [W-1:0] d);
`ifdef NTT_REORDER_CANON_EN
    return d >= MODULUS ? d - MODULUS : d;
`else
    return d;
`endif
  endfunction

  function automatic void model_in(logic [W-1:0] d);
    in_buf.push_back(canon(d));
    if (in_buf.size() == N) begin
      for (int i = 0; i < N; i++) exp_q.push_back(in_buf[rev(i)]);
      in_buf.delete();
    end
  endfunction

  function automatic void model_out(output bit have, output logic [W-1:0] ed, output logic el);
    have = exp_q.size() > 0;
    ed = '0;
    if (have) ed = exp_q.pop_front();
    el = out_idx == N - 1;
    out_idx = (out_idx + 1) % N;
  endfunction

  function automatic void model_reset();
    in_buf.delete();
    exp_q.delete();
    out_idx = 0;
  endfunction

  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy,
                       output logic acc, output logic xfer, output logic [W-1:0] od,
                       output logic ol, output logic ir, output logic ov);
    @(negedge clk);
    in_valid = iv;
    incoming_data = d;
    out_ready = ordy;
    ir = in_ready;
    ov = out_valid;
    od = reordered_data;
    ol = out_last;
    acc = iv && ir;
    xfer = ov && ordy;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    if (reordered_data !== '0) begin errors++; $display("FAIL reset_data: got %0d want 0", reordered_data); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_single();
    int exp_s[16];
    logic acc, xfer, ol, ir, ov, el;
    logic [W-1:0] od, ed;
    bit h;
    exp_s = '{100,108,104,112,102,110,106,114,101,109,105,113,103,111,107,115};
    for (int p = 0; p < N; p++) begin
      cycle(1, W'(100 + p), 1, acc, xfer, od, ol, ir, ov);
      if (acc) model_in(W'(100 + p));
      vectors++;
      if (ir !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL single_fill p=%0d: in_ready %b out_valid %b want 1 0", p, ir, ov); end
    end
    for (int j = 0; j < N; j++) begin
      cycle(0, '0, 1, acc, xfer, od, ol, ir, ov);
      vectors++;
      if (ov !== 1'b1 || od !== W'(exp_s[j]) || ol !== (j == N - 1)) begin
        errors++;
        $display("FAIL single_out j=%0d: valid %b data %0d last %b want 1 %0d %b", j, ov, od, ol, exp_s[j], j == N - 1);
      end
      if (xfer) model_out(h, ed, el);
    end
    cycle(0, '0, 1, acc, xfer, od, ol, ir, ov);
    vectors++;
    if (ov !== 1'b0) begin errors++; $display("FAIL single_end: out_valid %b want 0", ov); end
  endtask

  task automatic test_back_to_back();
    logic acc, xfer, ol, ir, ov, el;
    logic [W-1:0] od, ed, d;
    bit h;
    int outs = 0, first = -1, last = -1;
    for (int c = 0; c < 200 && outs < 4 * N; c++) begin
      d = W'($urandom_range(0, 2 * MODULUS - 1));
      cycle(c < 4 * N, d, 1, acc, xfer, od, ol, ir, ov);
      if (acc) model_in(d);
      if (c < 4 * N) begin
        vectors++;
        if (ir !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, ir); end
      end
      if (xfer) begin
        model_out(h, ed, el);
        vectors++;
        if (!h || od !== ed || ol !== el) begin errors++; $display("FAIL b2b_data: got %0d last %b want %0d last %b", od, ol, ed, el); end
        if (first < 0) first = c;
        last = c;
        outs++;
      end
    end
    vectors++;
    if (outs != 4 * N || last - first != 4 * N - 1) begin
      errors++;
      $display("FAIL b2b_contiguous: outs %0d span %0d want 64 63", outs, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic acc, xfer, ol, ir, ov, el;
    logic [W-1:0] od, ed, d;
    bit h;
    int sent = 0, outs = 0;
    bit seen_last = 0, check_next = 0;
    for (int c = 0; c < 400 && outs < 3 * N; c++) begin
      d = W'($urandom_range(0, 2 * MODULUS - 1));
      cycle(sent < 3 * N, d, c >= 40, acc, xfer, od, ol, ir, ov);
      if (check_next) begin
        vectors++;
        if (ir !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready %b want 1", ir); end
        check_next = 0;
      end else if (c >= 2 * N && !seen_last) begin
        vectors++;
        if (ir !== 1'b0) begin errors++; $display("FAIL bp_stall c=%0d: in_ready %b want 0", c, ir); end
      end
      if (acc) begin model_in(d); sent++; end
      if (c == 39) begin
        vectors++;
        if (sent != 2 * N) begin errors++; $display("FAIL bp_accepts: got %0d want 32", sent); end
      end
      if (xfer) begin
        model_out(h, ed, el);
        vectors++;
        if (!h || od !== ed || ol !== el) begin errors++; $display("FAIL bp_data: got %0d last %b want %0d last %b", od, ol, ed, el); end
        if (ol && !seen_last) begin seen_last = 1; check_next = 1; end
        outs++;
      end
    end
    vectors++;
    if (outs != 3 * N) begin errors++; $display("FAIL bp_drain: outs %0d want 48", outs); end
  endtask

  task automatic test_random();
    logic acc, xfer, ol, ir, ov, el, ordy, stall = 0;
    logic [W-1:0] od, ed, d, prev_od = '0;
    bit h;
    int sent = 0, outs = 0;
    for (int c = 0; c < 5000 && outs < 20 * N; c++) begin
      d = W'($urandom_range(0, 2 * MODULUS - 1));
      ordy = 1'($urandom % 2);
      cycle(sent < 20 * N && ($urandom % 2) == 1, d, ordy, acc, xfer, od, ol, ir, ov);
      if (stall) begin
        vectors++;
        if (ov !== 1'b1 || od !== prev_od) begin errors++; $display("FAIL rand_hold: valid %b data %0d want 1 %0d", ov, od, prev_od); end
      end
      stall = ov && !ordy;
      prev_od = od;
      if (acc) begin model_in(d); sent++; end
      if (xfer) begin
        model_out(h, ed, el);
        vectors++;
        if (!h || od !== ed || ol !== el) begin errors++; $display("FAIL rand_data: got %0d last %b want %0d last %b", od, ol, ed, el); end
        outs++;
      end
    end
    vectors++;
    if (outs != 20 * N || exp_q.size() != 0) begin errors++; $display("FAIL rand_count: outs %0d left %0d want 320 0", outs, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic acc, xfer, ol, ir, ov, el;
    logic [W-1:0] od, ed;
    bit h;
    int outs = 0;
    for (int p = 0; p < 7; p++) begin
      cycle(1, W'(300 + p), 1, acc, xfer, od, ol, ir, ov);
      if (acc) model_in(W'(300 + p));
    end
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || reordered_data !== '0) begin
        errors++;
        $display("FAIL rst_mid_outputs: ready %b valid %b last %b data %0d want 1 0 0 0", in_ready, out_valid, out_last, reordered_data);
      end
      @(negedge clk);
    end
    rst = 0;
    model_reset();
    for (int p = 0; p < N; p++) begin
      cycle(1, W'(200 + p), 1, acc, xfer, od, ol, ir, ov);
      if (acc) model_in(W'(200 + p));
      vectors++;
      if (ov !== 1'b0) begin errors++; $display("FAIL rst_mid_early: out_valid %b want 0 at p=%0d", ov, p); end
    end
    for (int c = 0; c < 40 && outs < N; c++) begin
      cycle(0, '0, 1, acc, xfer, od, ol, ir, ov);
      if (xfer) begin
        model_out(h, ed, el);
        vectors++;
        if (!h || od !== ed || ol !== el || od !== W'(200 + rev(outs))) begin
          errors++;
          $display("FAIL rst_mid_data: got %0d last %b want %0d last %b", od, ol, ed, el);
        end
        outs++;
      end
    end
    vectors++;
    if (outs != N) begin errors++; $display("FAIL rst_mid_count: outs %0d want 16", outs); end
  endtask

  task automatic test_canon();
    logic acc, xfer, ol, ir, ov, el;
    logic [W-1:0] od, ed, d, exp0;
    bit h;
`ifdef NTT_REORDER_CANON_EN
    exp0 = 9;
`else
    exp0 = 7690;
`endif
    for (int p = 0; p < N; p++) begin
      d = p == 0 ? W'(7690) : p == 1 ? W'(7680) : W'(p);
      cycle(1, d, 1, acc, xfer, od, ol, ir, ov);
      if (acc) model_in(d);
    end
    for (int j = 0; j < N; j++) begin
      cycle(0, '0, 1, acc, xfer, od, ol, ir, ov);
      if (xfer) model_out(h, ed, el);
      if (j == 0) begin
        vectors++;
        if (od !== exp0) begin errors++; $display("FAIL canon_7690: got %0d want %0d", od, exp0); end
      end
      if (j == N / 2) begin
        vectors++;
        if (od !== W'(7680)) begin errors++; $display("FAIL canon_7680: got %0d want 7680", od); end
      end
      if (j != 0 && j != N / 2) begin
        vectors++;
        if (!xfer || od !== ed) begin errors++; $display("FAIL canon_other j=%0d: got %0d want %0d", j, od, ed); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_canon();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
